irq_arbiter: RTL and testbench

- Sequences CPU interrupt entry and exit for NUM_IRQ edge-triggered sources.
- Latches pending sources, selects one by fixed priority, presents its vector to the core with a req/ack handshake, then blocks further interrupts until end-of-interrupt (EOI).
- Sits between peripheral trigger lines and the core's fetch/redirect logic.
- Configured through the same 3-bit-address, 32-bit write port style used by the other CPU-side config blocks.

---
 rtl/irq_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Brief    : Edge-triggered interrupt sequencer. Latches pending sources,
//            picks the lowest-index eligible one, hands its vector to the
//            core over a req/ack handshake and holds off further requests
//            until end-of-interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_trigger,
    input  logic               i_wr_en,
    input  logic [2:0]         i_addr,
    input  logic [31:0]        i_wr_port,
    input  logic               i_ack,
    input  logic               i_eoi,
    output logic               o_int,
    output logic [31:0]        o_addr,
    output logic [2:0]         o_id,
    output logic               o_busy,
    output logic [NUM_IRQ-1:0] o_pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;

    logic [NUM_IRQ-1:0]   prev;
    logic [NUM_IRQ-1:0]   pending;
    logic [NUM_IRQ-1:0]   pending_n;
    logic [NUM_IRQ-1:0]   enable;
    logic                 gen;
    logic [NUM_IRQ-1:0]   sel_oh;
    logic [2:0]           id_q;
    logic [31:0]          addr_q;

    logic [NUM_IRQ*32-1:0] vec_flat;

    logic [NUM_IRQ-1:0]   edges;
    logic [NUM_IRQ-1:0]   eligible;
    logic [NUM_IRQ-1:0]   pick_oh;
    logic [2:0]           pick_id;
    logic [31:0]          pick_vec;
    logic                 load_sel;
    logic                 ack_take;

    logic                 wr_mask;
    logic                 wr_gen;
    logic                 wr_clr;

    assign edges    = i_trigger & ~prev;
    assign eligible = pending & enable & {NUM_IRQ{gen}};
    assign wr_mask  = i_wr_en && (i_addr == 3'd4);
    assign wr_gen   = i_wr_en && (i_addr == 3'd5);
    assign wr_clr   = i_wr_en && (i_addr == 3'd6);

    // Vector storage: only the first four sources share the address space
    // with the control registers, so sources 4+ are hard-wired to RESET_VEC.
    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_vec
        if (k < 4) begin : g_wr
            logic [31:0] vec_q;
            // Per-source vector register, loaded from the config port.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    vec_q <= RESET_VEC;
                else if (i_wr_en && (i_addr == 3'(k)))
                    vec_q <= i_wr_port;
            end
            assign vec_flat[k*32 +: 32] = vec_q;
        end else begin : g_ro
            assign vec_flat[k*32 +: 32] = RESET_VEC;
        end
    end

    // Fixed-priority pick: scanning downward leaves the lowest set index.
    always_comb begin
        pick_id  = '0;
        pick_vec = RESET_VEC;
        pick_oh  = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                pick_id     = 3'(k);
                pick_vec    = vec_flat[k*32 +: 32];
                pick_oh     = '0;
                pick_oh[k]  = 1'b1;
            end
        end
    end

    // Next-state logic for the request/service sequence.
    always_comb begin
        state_n  = state;
        load_sel = 1'b0;
        ack_take = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    state_n  = ST_REQ;
                    load_sel = 1'b1;
                end
            end
            ST_REQ: begin
                // Ack wins over a disable that lands in the same cycle.
                if (i_ack) begin
                    state_n  = ST_SVC;
                    ack_take = 1'b1;
                end else if (!gen || ((sel_oh & enable) == '0)) begin
                    state_n  = ST_IDLE;
                end
            end
            ST_SVC: begin
                if (i_eoi)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Pending update: clears first, new edges applied last so a set wins.
    always_comb begin
        pending_n = pending;
        if (wr_clr)
            pending_n = pending_n & ~i_wr_port[NUM_IRQ-1:0];
        if (ack_take)
            pending_n = pending_n & ~sel_oh;
        pending_n = pending_n | edges;
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Trigger history, pending bits and control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev    <= '0;
            pending <= '0;
            enable  <= '0;
            gen     <= 1'b0;
        end else begin
            prev    <= i_trigger;
            pending <= pending_n;
            if (wr_mask)
                enable <= i_wr_port[NUM_IRQ-1:0];
            if (wr_gen)
                gen <= i_wr_port[0];
        end
    end

    // Selection capture; frozen until the next pick out of IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_oh <= '0;
            id_q   <= '0;
            addr_q <= '0;
        end else if (load_sel) begin
            sel_oh <= pick_oh;
            id_q   <= pick_id;
            addr_q <= pick_vec;
        end
    end

    assign o_int     = (state == ST_REQ);
    assign o_busy    = (state == ST_SVC);
    assign o_id      = id_q;
    assign o_addr    = addr_q;
    assign o_pending = pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter
// Brief    : Self-checking bench for irq_arbiter: directed scenarios plus a
//            randomized run compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

    localparam int          N  = 4;
    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic [N-1:0] trigger;
    logic        wr_en;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic        ack;
    logic        eoi;
    logic        o_int;
    logic [31:0] o_addr;
    logic [2:0]  o_id;
    logic        o_busy;
    logic [N-1:0] o_pending;

    int checks = 0;
    int errors = 0;

    irq_arbiter #(.NUM_IRQ(N), .RESET_VEC(RV)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_trigger (trigger),
        .i_wr_en   (wr_en),
        .i_addr    (addr),
        .i_wr_port (wr_data),
        .i_ack     (ack),
        .i_eoi     (eoi),
        .o_int     (o_int),
        .o_addr    (o_addr),
        .o_id      (o_id),
        .o_busy    (o_busy),
        .o_pending (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 = waiting, 1 = requesting, 2 = in service.
    int          m_phase;
    int          m_id;
    logic [31:0] m_addr;
    logic [N-1:0] m_pend, m_en, m_prev, m_e, m_clr, m_elig;
    logic        m_gen;
    logic [31:0] m_vec [N];
    bit          m_found;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_id = 0; m_addr = 32'h0;
            m_pend = '0; m_en = '0; m_prev = '0; m_gen = 1'b0;
            for (int k = 0; k < N; k++) m_vec[k] = RV;
        end else begin
            m_e   = trigger & ~m_prev;
            m_clr = '0;
            m_elig = m_pend & m_en & {N{m_gen}};
            if (m_phase == 0) begin
                m_found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!m_found && m_elig[k]) begin
                        m_found = 1; m_id = k; m_addr = m_vec[k]; m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (ack) begin
                    m_clr[m_id] = 1'b1; m_phase = 2;
                end else if (!m_gen || !m_en[m_id]) begin
                    m_phase = 0;
                end
            end else begin
                if (eoi) m_phase = 0;
            end
            if (wr_en) begin
                if (addr < 3'd4)       m_vec[addr[1:0]] = wr_data;
                else if (addr == 3'd4) m_en  = wr_data[N-1:0];
                else if (addr == 3'd5) m_gen = wr_data[0];
                else if (addr == 3'd6) m_clr = m_clr | wr_data[N-1:0];
            end
            m_pend = (m_pend & ~m_clr) | m_e;
            m_prev = trigger;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        tick();
        wr_en = 1'b0; addr = 3'd0; wr_data = 32'h0;
    endtask

    task automatic pulse(input logic [N-1:0] t);
        trigger = t;
        tick();
        trigger = '0;
    endtask

    task automatic test_reset();
        checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", o_int); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", o_addr); end
        checks++; if (o_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", o_id); end
        checks++; if (o_pending !== 4'b0000) begin errors++; $display("FAIL reset_pend: got %b want 0000", o_pending); end
    endtask

    task automatic test_basic();
        wr(3'd5, 32'h1);
        wr(3'd4, 32'h4);
        wr(3'd2, 32'h0000_0400);
        pulse(4'b0100);
        checks++; if (o_pending !== 4'b0100) begin errors++; $display("FAIL basic_pend: got %b want 0100", o_pending); end
        checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL basic_early_int: got %b want 0", o_int); end
        tick();
        checks++; if (o_int !== 1'b1) begin errors++; $display("FAIL basic_int: got %b want 1", o_int); end
        checks++; if (o_addr !== 32'h400) begin errors++; $display("FAIL basic_addr: got %h want 400", o_addr); end
        checks++; if (o_id !== 3'd2) begin errors++; $display("FAIL basic_id: got %0d want 2", o_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL basic_ack_int: got %b want 0", o_int); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", o_busy); end
        checks++; if (o_pending !== 4'b0000) begin errors++; $display("FAIL basic_ack_pend: got %b want 0000", o_pending); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_eoi_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_priority();
        wr(3'd4, 32'hF);
        wr(3'd1, 32'h0000_0100);
        wr(3'd3, 32'h0000_0300);
        pulse(4'b1010);
        tick();
        checks++; if (o_int !== 1'b1 || o_id !== 3'd1) begin errors++; $display("FAIL prio_first: got int=%b id=%0d want int=1 id=1", o_int, o_id); end
        checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL prio_first_addr: got %h want 100", o_addr); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        checks++; if (o_pending !== 4'b1000 || o_int !== 1'b0) begin errors++; $display("FAIL prio_after_eoi: got pend=%b int=%b want pend=1000 int=0", o_pending, o_int); end
        tick();
        checks++; if (o_int !== 1'b1 || o_id !== 3'd3) begin errors++; $display("FAIL prio_second: got int=%b id=%0d want int=1 id=3", o_int, o_id); end
        checks++; if (o_addr !== 32'h300) begin errors++; $display("FAIL prio_second_addr: got %h want 300", o_addr); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_mask();
        wr(3'd4, 32'hE);
        pulse(4'b0001);
        tick(); tick();
        checks++; if (o_pending[0] !== 1'b1 || o_int !== 1'b0) begin errors++; $display("FAIL mask_hold: got pend0=%b int=%b want pend0=1 int=0", o_pending[0], o_int); end
        wr(3'd4, 32'h1);
        checks++; if (o_int !== 1'b0) begin errors++; $display("FAIL mask_wr_cycle: got %b want 0", o_int); end
        tick();
        checks++; if (o_int !== 1'b1 || o_id !== 3'd0) begin errors++; $display("FAIL mask_release: got int=%b id=%0d want int=1 id=0", o_int, o_id); end
        checks++; if (o_addr !== RV) begin errors++; $display("FAIL mask_resetvec: got %h want %h", o_addr, RV); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_disable_req();
        pulse(4'b0001);
        tick();
        checks++; if (o_int !== 1'b1) begin errors++; $display("FAIL dis_req: got %b want 1", o_int); end
        wr(3'd5, 32'h0);
        checks++; if (o_int !== 1'b1) begin errors++; $display("FAIL dis_wr_cycle: got %b want 1", o_int); end
        tick();
        checks++; if (o_int !== 1'b0 || o_pending[0] !== 1'b1) begin errors++; $display("FAIL dis_drop: got int=%b pend0=%b want int=0 pend0=1", o_int, o_pending[0]); end
        wr(3'd5, 32'h1);
        tick();
        checks++; if (o_int !== 1'b1 || o_id !== 3'd0) begin errors++; $display("FAIL dis_rereq: got int=%b id=%0d want int=1 id=0", o_int, o_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_collision();
        pulse(4'b0001);
        tick();
        ack = 1'b1; trigger = 4'b0001;
        tick();
        ack = 1'b0; trigger = '0;
        checks++; if (o_busy !== 1'b1 || o_pending[0] !== 1'b1) begin errors++; $display("FAIL coll_ack: got busy=%b pend0=%b want busy=1 pend0=1", o_busy, o_pending[0]); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        checks++; if (o_int !== 1'b1 || o_id !== 3'd0) begin errors++; $display("FAIL coll_rereq: got int=%b id=%0d want int=1 id=0", o_int, o_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        // Masked sources collect pending bits that are then cleared by W1C.
        pulse(4'b1110);
        tick();
        checks++; if (o_pending !== 4'b1110 || o_int !== 1'b0) begin errors++; $display("FAIL w1c_setup: got pend=%b int=%b want pend=1110 int=0", o_pending, o_int); end
        wr(3'd6, 32'hF);
        checks++; if (o_pending !== 4'b0000) begin errors++; $display("FAIL w1c_clear: got %b want 0000", o_pending); end
        wr_en = 1'b1; addr = 3'd6; wr_data = 32'hF; trigger = 4'b0010;
        tick();
        wr_en = 1'b0; addr = 3'd0; wr_data = 32'h0; trigger = '0;
        checks++; if (o_pending !== 4'b0010) begin errors++; $display("FAIL w1c_set_wins: got %b want 0010", o_pending); end
        wr(3'd6, 32'hF);
        checks++; if (o_pending !== 4'b0000) begin errors++; $display("FAIL w1c_clear2: got %b want 0000", o_pending); end
    endtask

    task automatic test_async_reset();
        wr(3'd4, 32'h4);
        pulse(4'b0100);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        pulse(4'b1000);
        checks++; if (o_busy !== 1'b1 || o_pending !== 4'b1000) begin errors++; $display("FAIL arst_setup: got busy=%b pend=%b want busy=1 pend=1000", o_busy, o_pending); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (o_int !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL arst_ctl: got int=%b busy=%b want 0 0", o_int, o_busy); end
        checks++; if (o_addr !== 32'h0 || o_id !== 3'd0) begin errors++; $display("FAIL arst_sel: got addr=%h id=%0d want 0 0", o_addr, o_id); end
        checks++; if (o_pending !== 4'b0000) begin errors++; $display("FAIL arst_pend: got %b want 0000", o_pending); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr(3'd5, 32'h1);
        wr(3'd4, 32'h4);
        pulse(4'b0100);
        tick();
        checks++; if (o_int !== 1'b1 || o_id !== 3'd2) begin errors++; $display("FAIL arst_rereq: got int=%b id=%0d want int=1 id=2", o_int, o_id); end
        checks++; if (o_addr !== RV) begin errors++; $display("FAIL arst_vec: got %h want %h", o_addr, RV); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            trigger = N'($urandom);
            wr_en   = ($urandom_range(0, 3) == 0);
            addr    = 3'($urandom_range(0, 7));
            wr_data = (addr == 3'd5) ? {31'h0, ($urandom_range(0, 3) != 0)} : $urandom;
            ack     = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 3) == 0);
            tick();
            checks++; if (o_int !== (m_phase == 1)) begin errors++; $display("FAIL rnd_int c=%0d: got %b want %b", c, o_int, (m_phase == 1)); end
            checks++; if (o_busy !== (m_phase == 2)) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, o_busy, (m_phase == 2)); end
            checks++; if (o_pending !== m_pend) begin errors++; $display("FAIL rnd_pend c=%0d: got %b want %b", c, o_pending, m_pend); end
            checks++; if (o_id !== 3'(m_id)) begin errors++; $display("FAIL rnd_id c=%0d: got %0d want %0d", c, o_id, m_id); end
            checks++; if (o_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, o_addr, m_addr); end
        end
        trigger = '0; wr_en = 1'b0; addr = 3'd0; wr_data = 32'h0; ack = 1'b0; eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; trigger = '0; wr_en = 1'b0; addr = 3'd0;
        wr_data = 32'h0; ack = 1'b0; eoi = 1'b0;
        #22;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_disable_req();
        test_collision();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
